// File: rtl/decoder_pkg.sv
// Shared widths, FSM encoding and code-to-line helper for the sequential 3-to-8 decoder.
package decoder_pkg;
  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    return OUT_W'(1) << code;
  endfunction
endpackage

// File: rtl/code_fifo.sv
// Synchronous FIFO, combinational head on dout; push ignored when full, pop ignored when empty.
// Pointers wrap naturally at DEPTH (power of 2); level tracks occupancy 0..DEPTH.
module code_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Fullness is judged before any same-cycle pop, so a full FIFO refuses the push.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/decoder_pulse.sv
// Buffers 3-bit codes and replays each as a PULSE_LEN-cycle one-hot on X, then GAP_LEN zero cycles and one IDLE cycle.
// First pulse appears one cycle after the pop edge; in_ready = !full, en only gates leaving IDLE.
module decoder_pulse
  import decoder_pkg::*;
#(
  parameter int PULSE_LEN  = 1,
  parameter int GAP_LEN    = 0,
  parameter int FIFO_DEPTH = 4,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  input  logic              en,
  output logic [OUT_W-1:0]  X,
  output logic              busy,
  output logic              pulse_done,
  output logic [LW-1:0]     level
);
  localparam int MAXL = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;

  state_t            state;
  state_t            state_d;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_d;
  logic [OUT_W-1:0]  x_d;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CODE_W-1:0] head;

  code_fifo #(.WIDTH(CODE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .din   (in_code),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign in_ready = !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      X     <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      X     <= x_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    x_d     = X;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        x_d = '0;
        if (en && !empty) begin
          pop     = 1'b1;
          x_d     = onehot(head);
          cnt_d   = PULSE_LOAD;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          x_d = '0;
          if (GAP_LEN > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      GAP: begin
        x_d = '0;
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - CW'(1);
      end
      default: begin
        state_d = IDLE;
        x_d     = '0;
      end
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    pulse_done = (state == PULSE) && (cnt == '0);
  end
endmodule

// File: tb/tb_decoder_pulse.sv
// Bench for decoder_pulse: three parameterisations (P1/G0, P3/G2, P4/G0) against a slot-timing reference model.
module tb_decoder_pulse;
  logic       clk;
  logic       rst;
  logic       in_valid [3];
  logic [2:0] in_code  [3];
  logic       in_ready [3];
  logic       en       [3];
  logic [7:0] X        [3];
  logic       busy     [3];
  logic       pulse_done [3];
  logic [2:0] level    [3];

  int checks = 0;
  int failures = 0;

  decoder_pulse #(.PULSE_LEN(1), .GAP_LEN(0), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_code(in_code[0]), .in_ready(in_ready[0]),
    .en(en[0]), .X(X[0]), .busy(busy[0]), .pulse_done(pulse_done[0]), .level(level[0]));
  decoder_pulse #(.PULSE_LEN(3), .GAP_LEN(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_code(in_code[1]), .in_ready(in_ready[1]),
    .en(en[1]), .X(X[1]), .busy(busy[1]), .pulse_done(pulse_done[1]), .level(level[1]));
  decoder_pulse #(.PULSE_LEN(4), .GAP_LEN(0), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_code(in_code[2]), .in_ready(in_ready[2]),
    .en(en[2]), .X(X[2]), .busy(busy[2]), .pulse_done(pulse_done[2]), .level(level[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: each instance is "t edges since its last pop"; a pulse owns t in [0,P), gap [P,P+G), idle after.
  localparam int IDLE_T = 1000;
  localparam int DEPTH  = 4;
  logic [2:0] mq [3][$];
  int         mt [3];
  logic [2:0] mcur [3];

  function automatic int pl(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 4;
  endfunction
  function automatic int gl(input int i);
    return (i == 1) ? 2 : 0;
  endfunction
  function automatic logic [2:0] enc(input logic [7:0] x);
    logic [2:0] r = 3'd0;
    for (int b = 0; b < 8; b++) if (x[b]) r = 3'(b);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mt[i] = IDLE_T;
      mcur[i] = 3'd0;
    end
  endtask

  task automatic model_edge(input int i);
    int sz;
    bit push_ok;
    sz = mq[i].size();
    push_ok = in_valid[i] && (sz < DEPTH);
    if (mt[i] >= pl(i) + gl(i) && en[i] && sz > 0) begin
      mcur[i] = mq[i].pop_front();
      mt[i] = 0;
    end else if (mt[i] < IDLE_T) begin
      mt[i]++;
    end
    if (push_ok) mq[i].push_back(in_code[i]);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare(input int i);
    logic [7:0] ex;
    int p, g;
    p = pl(i);
    g = gl(i);
    ex = (mt[i] < p) ? (8'd1 << mcur[i]) : 8'd0;
    chk($sformatf("model_u%0d", i),
        {18'd0, X[i], busy[i], pulse_done[i], level[i], in_ready[i]},
        {18'd0, ex, 1'(mt[i] < p + g), 1'(mt[i] == p - 1), 3'(mq[i].size()), 1'(mq[i].size() < DEPTH)});
    chk($sformatf("onehot_u%0d", i), 32'((X[i] == 8'd0) || $onehot(X[i])), 32'd1);
  endtask

  bit         collect = 0;
  logic [7:0] prev_x = 8'd0;
  logic [2:0] seq [$];

  task automatic step();
    if (rst) model_reset();
    else for (int i = 0; i < 3; i++) model_edge(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) model_compare(i);
    if (collect) begin
      chk("no_touch", 32'(prev_x != 8'd0 && X[0] != 8'd0), 32'd0);
      if (X[0] != 8'd0) seq.push_back(enc(X[0]));
      prev_x = X[0];
    end
  endtask

  task automatic set_all(input logic v, input logic e);
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = v;
      in_code[i]  = 3'd5;
      en[i]       = e;
    end
  endtask

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic       e;
    logic [7:0] x;
    logic       pd;
    logic       b;
    logic [2:0] lv;
    logic       rdy;
  } vec_t;

  vec_t tbl [19];
  logic [7:0] exp5_x  [11];
  logic       exp5_pd [11];

  initial begin
    int k;
    logic rdy;
    // single code 5, then en=0 fill/backpressure and drain
    tbl[0]  = '{1, 3'd5, 1, 8'h00, 0, 0, 3'd1, 1};
    tbl[1]  = '{0, 3'd0, 1, 8'h20, 1, 1, 3'd0, 1};
    tbl[2]  = '{0, 3'd0, 1, 8'h00, 0, 0, 3'd0, 1};
    tbl[3]  = '{0, 3'd0, 1, 8'h00, 0, 0, 3'd0, 1};
    tbl[4]  = '{1, 3'd1, 0, 8'h00, 0, 0, 3'd1, 1};
    tbl[5]  = '{1, 3'd2, 0, 8'h00, 0, 0, 3'd2, 1};
    tbl[6]  = '{1, 3'd3, 0, 8'h00, 0, 0, 3'd3, 1};
    tbl[7]  = '{1, 3'd4, 0, 8'h00, 0, 0, 3'd4, 0};
    tbl[8]  = '{1, 3'd6, 0, 8'h00, 0, 0, 3'd4, 0};
    tbl[9]  = '{1, 3'd6, 1, 8'h02, 1, 1, 3'd3, 1};
    tbl[10] = '{1, 3'd6, 1, 8'h00, 0, 0, 3'd4, 0};
    tbl[11] = '{0, 3'd0, 1, 8'h04, 1, 1, 3'd3, 1};
    tbl[12] = '{0, 3'd0, 1, 8'h00, 0, 0, 3'd3, 1};
    tbl[13] = '{0, 3'd0, 1, 8'h08, 1, 1, 3'd2, 1};
    tbl[14] = '{0, 3'd0, 1, 8'h00, 0, 0, 3'd2, 1};
    tbl[15] = '{0, 3'd0, 1, 8'h10, 1, 1, 3'd1, 1};
    tbl[16] = '{0, 3'd0, 1, 8'h00, 0, 0, 3'd1, 1};
    tbl[17] = '{0, 3'd0, 1, 8'h40, 1, 1, 3'd0, 1};
    tbl[18] = '{0, 3'd0, 1, 8'h00, 0, 0, 3'd0, 1};
    exp5_x  = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h40, 8'h40, 8'h40, 8'h00};
    exp5_pd = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};

    model_reset();
    rst = 1'b1;
    set_all(1'b1, 1'b1);

    // Reset held with a valid code presented
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_hold", {29'd0, 1'(X[0] != 8'd0), level[0] != 3'd0 ? 1'b1 : 1'b0, in_ready[0]}, 32'd1);
    end
    rst = 1'b0;
    set_all(1'b0, 1'b0);

    for (int r = 0; r < 19; r++) begin
      in_valid[0] = tbl[r].v;
      in_code[0]  = tbl[r].c;
      en[0]       = tbl[r].e;
      step();
      chk($sformatf("tbl_row%0d", r), {18'd0, X[0], pulse_done[0], busy[0], level[0], in_ready[0]},
          {18'd0, tbl[r].x, tbl[r].pd, tbl[r].b, tbl[r].lv, tbl[r].rdy});
    end

    // Stream 0..7 through the encoder view
    k = 0;
    collect = 1;
    en[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_valid[0] = (k < 8);
      in_code[0]  = 3'(k);
      rdy = in_ready[0];
      step();
      if (k < 8 && rdy) k++;
    end
    collect = 0;
    in_valid[0] = 1'b0;
    chk("stream_pushed", 32'(k), 32'd8);
    chk("stream_count", 32'(seq.size()), 32'd8);
    for (int j = 0; j < 8 && j < seq.size(); j++) chk($sformatf("stream_a%0d", j), 32'(seq[j]), 32'(j));

    // Randomised traffic on all instances
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid[i] = ($urandom_range(0, 9) < 7);
        in_code[i]  = 3'($urandom_range(0, 7));
        en[i]       = ($urandom_range(0, 9) < 8);
      end
      step();
    end

    set_all(1'b0, 1'b1);
    for (int c = 0; c < 40; c++) step();
    chk("drain_level", {29'd0, level[0] | level[1] | level[2]}, 32'd0);

    // PULSE_LEN=3, GAP_LEN=2: codes 2 then 6
    for (int c = 0; c < 11; c++) begin
      in_valid[1] = (c < 2);
      in_code[1]  = (c == 0) ? 3'd2 : 3'd6;
      step();
      chk($sformatf("p3g2_x%0d", c), 32'(X[1]), 32'(exp5_x[c]));
      chk($sformatf("p3g2_pd%0d", c), 32'(pulse_done[1]), 32'(exp5_pd[c]));
    end
    in_valid[1] = 1'b0;
    for (int c = 0; c < 5; c++) step();

    // PULSE_LEN=4: reset in the second pulse cycle of code 7, code 1 must vanish
    for (int c = 0; c < 3; c++) begin
      in_valid[2] = (c < 2);
      in_code[2]  = (c == 0) ? 3'd7 : 3'd1;
      step();
    end
    in_valid[2] = 1'b0;
    chk("mid_pulse_x", 32'(X[2]), 32'h80);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_x", 32'(X[2]), 32'd0);
    chk("rst_async_lv", 32'(level[2]), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("no_code1", 32'(X[2] == 8'h02), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decoder_pulse.md
Name: decoder_pulse

Overview:
Sequential 3-to-8 decoder; the counterpart of the team's 8x3 encoder. It accepts 3-bit codes over a valid/ready interface, buffers them in a small FIFO, and replays each code as a timed one-hot pulse on X[7:0]. The pulse has the same form the encoder expects on its input: exactly one line high, all others 0. It sits upstream of the encoder in bench and self-test setups, so the X → A round trip can be checked.

Parameters:
PULSE_LEN, 1, cycles X stays one-hot per code; legal range ≥1.
GAP_LEN, 0, extra all-zero cycles after each pulse, before the mandatory IDLE cycle; legal range ≥0.
FIFO_DEPTH, 4, code buffer entries; must be a power of 2, ≥2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_code is valid
in_code  input  3  code to decode (binary index of line to pulse)
in_ready  output  1  FIFO can accept; equals !full
en  input  1  permits starting a new pulse
X  output  8  registered one-hot pulse output, 0 when idle
busy  output  1  state != IDLE
pulse_done  output  1  one-cycle strobe during last PULSE cycle
level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): X=0, busy=0, pulse_done=0, level=0, in_ready=1, FIFO emptied, state=IDLE.
- Push: occurs on a clock edge where in_valid && in_ready. in_ready is combinational !full.
  - When full, a push is refused even if a pop happens in the same cycle.
  - When not full, a simultaneous push and pop leaves level unchanged.
- FSM states: IDLE, PULSE, GAP. The state, X, and counter are all registered.
- IDLE:
  - X=0.
  - If en && level>0: pop the head code c, load X = 8'b1 << c, counter = PULSE_LEN-1, go to PULSE.
  - Otherwise stay in IDLE.
- PULSE:
  - X holds one-hot.
  - If counter==0: pulse_done=1 (combinational from state and counter); next state is GAP with counter=GAP_LEN-1 if GAP_LEN>0, else IDLE. X is cleared on the same edge.
  - Otherwise decrement counter.
- GAP:
  - X=0.
  - If counter==0, go to IDLE; otherwise decrement counter.
- Latency: a code accepted at edge E into an empty FIFO with the FSM in IDLE and en=1 appears on X in the cycle after edge E+1 (pop at E+1).
- Throughput: one code per PULSE_LEN + GAP_LEN + 1 cycles. The IDLE cycle always separates pulses, so back-to-back one-hot values never touch.
- en:
  - en=0 only blocks leaving IDLE.
  - An in-flight PULSE/GAP always completes.
  - The FIFO keeps accepting codes until full.
- All eight codes 0..7 are legal. X is never multi-hot.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. level saturates at neither end; overflow and underflow are prevented by in_ready and the level>0 check.
- Reset mid-pulse: X drops to 0 immediately (async), and buffered codes are discarded.

Decomposition:
- Package decoder_pkg:
  - CODE_W=3
  - OUT_W=8
  - state enum {IDLE, PULSE, GAP}
  - function onehot(code) returning OUT_W bits
- Sub-module code_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports clk, rst, push, pop, din, dout, full, empty, level. decoder_pulse instantiates one code_fifo and contains the FSM and counter.

Test Plan:
1. Reset check: with rst=1, drive in_valid=1, in_code=5, en=1 for 3 cycles, then release → X=0, level=0, in_ready=1 throughout reset; nothing decoded until after release.
2. Single code, default parameters: push 5 at edge E → X=8'h20 for exactly one cycle after E+1; pulse_done=1 in that cycle; X=0 before and after; busy deasserts one cycle later.
3. All codes streamed 0..7 with en=1, chained into the team's encoder → X = 01,02,04,...,80, each one cycle wide with 1 zero cycle between; encoder A = 0..7 in order; no multi-hot value at any cycle.
4. Backpressure: en=0, push 5 codes → in_ready=0 after the 4th push, level=4, 5th code held on the bus. Raise en → FIFO drains, 5th code is accepted once level drops to 3, and all 5 codes appear in order.
5. PULSE_LEN=3, GAP_LEN=2: push 2 then 6 → X=04 for 3 cycles, 0 for 3 cycles (2 gap + 1 idle), then X=40 for 3 cycles; pulse_done asserts only on the 3rd cycle of each pulse.
6. Reset mid-pulse: PULSE_LEN=4, push 7 and 1; assert rst in the 2nd pulse cycle → X=0 in the same cycle (before next edge), level=0, and code 1 never appears after release.
